// File: rtl/sa_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sa_pkg
// Description : Shared types and helpers for the systolic-array result path.
// Revision    : 1.0 - initial release
// ============================================================================
package sa_pkg;

    // Result-reader FSM states
    typedef enum logic [1:0] {
        RD_IDLE   = 2'd0,
        RD_ACK    = 2'd1,
        RD_STREAM = 2'd2
    } rd_state_t;

    // Index width for n entries, never narrower than one bit
    function automatic int row_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : sa_pkg
`default_nettype wire

// File: rtl/sa_result_reader.sv
`default_nettype none
// ============================================================================
// Module      : sa_result_reader
// Description : Snapshots the core's column result buffers once every column
//               is valid, acknowledges the core with a one-cycle outread
//               pulse, then serializes the snapshot as a valid/ready stream.
// Revision    : 1.0 - initial release
// ============================================================================
module sa_result_reader
    import sa_pkg::*;
#(
    parameter int  ROWS     = 8,
    parameter int  OUTWIDTH = 32,
    parameter int  CNTWIDTH = 16,
    localparam int RW       = row_w(ROWS)
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [OUTWIDTH-1:0] routport [0:ROWS-1],
    input  logic [0:ROWS-1]     rvalidport,
    output logic                outread,
    output logic [OUTWIDTH-1:0] m_data,
    output logic [RW-1:0]       m_row,
    output logic                m_last,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [CNTWIDTH-1:0] tile_cnt
);

    localparam logic [RW-1:0] c_LAST_ROW = RW'(ROWS - 1);

    rd_state_t           r_state;
    logic [RW-1:0]       r_idx;
    logic [OUTWIDTH-1:0] r_buf [0:ROWS-1];
    logic [RW-1:0]       w_idx_nxt;

    // Next row index, only used while a non-final word is handed off
    assign w_idx_nxt = r_idx + 1'b1;

    // Capture / acknowledge / stream sequencer with registered outputs.
    // The first stream cycle loads the output registers, so m_valid rises
    // one cycle after entering RD_STREAM; after that a word moves per cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= RD_IDLE;
            r_idx    <= '0;
            outread  <= 1'b0;
            m_data   <= '0;
            m_row    <= '0;
            m_last   <= 1'b0;
            m_valid  <= 1'b0;
            tile_cnt <= '0;
            for (int i = 0; i < ROWS; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            outread <= 1'b0;
            case (r_state)
                RD_IDLE: begin
                    // Only a complete set of column results is taken
                    if (&rvalidport) begin
                        for (int i = 0; i < ROWS; i++) begin
                            r_buf[i] <= routport[i];
                        end
                        outread <= 1'b1;
                        r_state <= RD_ACK;
                    end
                end
                RD_ACK: begin
                    r_idx   <= '0;
                    r_state <= RD_STREAM;
                end
                RD_STREAM: begin
                    if (!m_valid) begin
                        m_valid <= 1'b1;
                        m_data  <= r_buf[r_idx];
                        m_row   <= r_idx;
                        m_last  <= (r_idx == c_LAST_ROW);
                    end else if (m_ready) begin
                        if (m_last) begin
                            m_valid  <= 1'b0;
                            m_last   <= 1'b0;
                            tile_cnt <= tile_cnt + 1'b1;
                            r_state  <= RD_IDLE;
                        end else begin
                            r_idx  <= w_idx_nxt;
                            m_data <= r_buf[w_idx_nxt];
                            m_row  <= w_idx_nxt;
                            m_last <= (w_idx_nxt == c_LAST_ROW);
                        end
                    end
                end
                default: r_state <= RD_IDLE;
            endcase
        end
    end

endmodule : sa_result_reader
`default_nettype wire

// File: doc/sa_result_reader.md
# sa_result_reader

Drains the column result buffers of the systolic-array core and presents them as a single-word valid/ready stream for the wrapper or testbench. Once every column reports valid, it snapshots all `ROWS` results and pulses the core's `outread` input for one cycle, which frees the core to continue. It then serializes the snapshot one word per handshake. It sits between the core's `routport`/`rvalidport`/`outread` interface and any downstream sink.

## Interface
- `ROWS`, default 8: number of result columns; must match the core.
- `OUTWIDTH`, default 32: result word width; must match the core.
- `CNTWIDTH`, default 16: width of the completed-tile counter.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `routport`  in  `[OUTWIDTH-1:0]` x `[0:ROWS-1]`  per-column results from the core.
- `rvalidport`  in  `[0:ROWS-1]`  per-column result-valid from the core.
- `outread`  out  1  one-cycle pulse to the core: all buffered results have been taken.
- `m_data`  out  `OUTWIDTH`  current stream word.
- `m_row`  out  `$clog2(ROWS)` (min 1)  column index of `m_data`.
- `m_last`  out  1  high on the final word (`m_row == ROWS-1`).
- `m_valid`  out  1  stream word valid.
- `m_ready`  in  1  sink accepts the word.
- `tile_cnt`  out  `CNTWIDTH`  number of fully streamed tiles; wraps modulo 2^`CNTWIDTH`.

## Operation
- FSM states: `RD_IDLE`, `RD_ACK`, `RD_STREAM`.
- `RD_IDLE`: wait for `rvalidport` to be all ones.
  - A partial `rvalidport` is ignored; no capture.
  - On all ones: latch all `routport` words into an internal `ROWS`-entry buffer, then go to `RD_ACK`.
- `RD_ACK`: for exactly one cycle, `outread` = 1.
  - Row index is cleared to 0.
  - Next state is `RD_STREAM`.
- `RD_STREAM`:
  - `m_valid` = 1, `m_data` = buf[idx], `m_row` = idx, `m_last` = (idx == ROWS-1).
  - Handshake occurs when `m_valid && m_ready`.
  - On a handshake with `m_last` = 0: idx increments.
  - On a handshake with `m_last` = 1: `tile_cnt` increments and the FSM returns to `RD_IDLE`.
- `rvalidport` is not sampled outside `RD_IDLE`. A new all-ones pattern arriving during `RD_ACK` or `RD_STREAM` waits until `RD_IDLE`.
- The core must drop `rvalidport` within one cycle of `outread`. This guarantees that re-entering `RD_IDLE` never re-captures the same tile.
- The buffer is written only on capture. The core is free to refill its buffers while streaming is in progress.
- `ROWS` = 1: the stream is a single word with `m_last` = 1.

## Timing
- All outputs are registered.
- Reset values (asynchronous, on `rstn` = 0):
  - state = `RD_IDLE`
  - `outread` = 0, `m_valid` = 0, `m_last` = 0
  - `m_data` = 0, `m_row` = 0, `tile_cnt` = 0
  - buffer cleared to 0
- Latency, with all-ones `rvalidport` sampled at edge k:
  - `outread` is high during cycle k..k+1.
  - `m_valid` is first high after edge k+2.
  - With `m_ready` held high, one word per cycle; the tile takes `ROWS` + 2 cycles from capture to return to `RD_IDLE`.
- Back-pressure: while `m_valid` && !`m_ready`, the outputs `m_data`, `m_row`, `m_last` and `m_valid` hold stable.
- `m_ready` is ignored when `m_valid` = 0.
- Reset mid-stream: the FSM returns to `RD_IDLE` immediately.
  - The partial tile is discarded and `tile_cnt` is cleared.
  - No `outread` is issued for it.
- `tile_cnt` wraps from 2^`CNTWIDTH`-1 to 0 with no flag.

## Structure
- Shared package `sa_pkg`:
  - `typedef enum logic [1:0] {RD_IDLE, RD_ACK, RD_STREAM} rd_state_t`
  - row-index width helper: `$clog2` with a minimum of 1
- No sub-module; a single flat block (FSM, buffer, index counter, tile counter).

## Test plan
- Basic drain:
  - Stimulus: `ROWS`=8, results `routport[i]` = 0x100+i, `rvalidport` = 0xFF for one cycle, `m_ready` = 1.
  - Required: one `outread` pulse; `m_data` 0x100..0x107 in order, `m_row` 0..7, `m_last` on 0x107 only; `tile_cnt` = 1.
- Partial valid:
  - Stimulus: `rvalidport` = 0x7F held for 10 cycles, then 0xFF.
  - Required: no `outread` and no `m_valid` until 0xFF; then normal drain.
- Back-pressure:
  - Stimulus: `m_ready` toggled 1,0,0,1 repeatedly.
  - Required: `m_data`/`m_row` stable while stalled; all 8 words delivered exactly once; no duplicates or skips.
- Overlap:
  - Stimulus: second tile (0x200+i) with `rvalidport` = 0xFF asserted three cycles into streaming of the first tile.
  - Required: first tile is unaffected; the second is captured on the first `RD_IDLE` cycle; `tile_cnt` = 2 at the end.
- Reset mid-stream:
  - Stimulus: `rstn` low after word 3 is accepted.
  - Required: all outputs are 0 asynchronously; after release, the next 0xFF tile streams from `m_row` 0.
- Counter wrap:
  - Stimulus: `CNTWIDTH` = 2, five tiles.
  - Required: `tile_cnt` reads 1,2,3,0,1.
